ff_fifo_ctrl: RTL
=================

// Module: ff_fifo_ctrl
//
// PURPOSE
//  Pointer/flag controller that turns a flip-flop memory (1 write port, async read) into a show-ahead FIFO.
//  Sits between an upstream producer (valid/ready) and a downstream consumer inside the crypto datapath.
//  Drives the memory's write strobe, write address, write data and read address; returns its read data to the consumer.
//  Holds no storage of its own apart from the pointers.
//
// PARAMETERS
//  DW         8          data width; must equal the DW of the attached memory
//  AW         4          address width; DEPTH = 2**AW entries; must equal the AW of the attached memory
//  AFULL_THR  2**AW-2    almost_full asserts when count >= AFULL_THR; legal range 1..2**AW
//
// PORTS
//  clk          in   1     clock, all logic on rising edge
//  rst_n        in   1     reset, asynchronous, active-low
//  flush        in   1     synchronous clear of FIFO contents
//  s_valid      in   1     upstream data valid
//  s_ready      out  1     FIFO can accept a word
//  s_data       in   DW    upstream data
//  m_valid      out  1     FIFO holds at least one word
//  m_ready      in   1     downstream accepts head word
//  m_data       out  DW    head word (show-ahead)
//  count        out  AW+1  current occupancy, 0..2**AW
//  almost_full  out  1     count >= AFULL_THR
//  mem_wr_en    out  1     memory write strobe
//  mem_wr_addr  out  AW    memory write address
//  mem_din      out  DW    memory write data
//  mem_rd_addr  out  AW    memory read address
//  mem_dout     in   DW    memory async read data
//
// BEHAVIOUR
//  - State: wr_ptr, rd_ptr, each AW+1 bits (MSB = wrap bit). Reset (rst_n=0): both 0, so count=0, m_valid=0, s_ready=1,
//    almost_full=0, mem_wr_en=0. Reset mid-operation discards all contents immediately; memory contents are not cleared.
//  - empty = (wr_ptr == rd_ptr); full = (wr_ptr[AW-1:0]==rd_ptr[AW-1:0]) && (wr_ptr[AW]!=rd_ptr[AW]).
//  - s_ready = !full && !flush; m_valid = !empty; push = s_valid && s_ready; pop = m_valid && m_ready && !flush.
//  - mem_wr_en = push; mem_wr_addr = wr_ptr[AW-1:0]; mem_din = s_data (all combinational).
//  - mem_rd_addr = rd_ptr[AW-1:0]; m_data = mem_dout (combinational; value undefined while m_valid=0).
//  - On clk: push -> wr_ptr+1; pop -> rd_ptr+1; both in same cycle legal whenever neither is blocked; count unchanged.
//  - Pointers wrap modulo 2**(AW+1); address wraps from 2**AW-1 to 0 with wrap bit toggling.
//  - count = wr_ptr - rd_ptr (AW+1-bit modular subtract), combinational from registered pointers.
//  - almost_full = (count >= AFULL_THR), combinational from count.
//  - Latency: word pushed in cycle N appears on m_data with m_valid=1 in cycle N+1 (no fall-through when empty).
//  - Full: s_ready=0, no write even if m_ready=1 that cycle (no pass-through); s_ready returns 1 the cycle after a pop.
//  - Empty: m_valid=0, m_ready ignored, rd_ptr holds.
//  - flush=1: s_ready=0, mem_wr_en=0, no pop; next edge sets wr_ptr=rd_ptr=0. flush has priority over push/pop.
//  - s_data must be held stable by upstream while s_valid=1 && s_ready=0 (standard valid/ready; not checked here).
//
// TESTING  (bench uses DW=8, AW=2, AFULL_THR=3, this block wired to a 4-entry flip-flop memory)
//  1 Reset: rst_n low mid-stream with 2 words stored -> count=0, m_valid=0, s_ready=1, almost_full=0 asynchronously.
//  2 Fill: push 8'h11,22,33,44 back-to-back, m_ready=0 -> count 1..4, almost_full at count=3, s_ready=0 after 4th push;
//    5th s_valid with 8'h55 ignored, mem_wr_en=0.
//  3 Drain: from test 2, m_ready=1 four cycles -> m_data 11,22,33,44 in order, m_valid=0 after, count=0.
//  4 Wrap + simultaneous: stream 10 words with s_valid=m_ready=1 continuously -> all received in order, count stays 1 in
//    steady state, pointers wrap twice without loss.
//  5 Full + m_ready: full FIFO, s_valid=1 and m_ready=1 same cycle -> pop only, count 4->3; push accepted next cycle.
//  6 Flush: 3 words stored, flush=1 with s_valid=m_ready=1 -> no write, no pop; next cycle count=0, m_valid=0, s_ready=1.

Source files
------------

// File: rtl/ff_fifo_ctrl.sv
// Pointer and flag controller for a show-ahead FIFO built on an external
// flip-flop memory with one write port and an asynchronous read port.
module ff_fifo_ctrl #(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int AFULL_THR = 2**AW - 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW:0]   count,
    output logic          almost_full,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_din,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THR);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign s_ready = !full && !flush;
    assign m_valid = !empty;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready && !flush;

    assign mem_wr_en   = push;
    assign mem_wr_addr = wr_ptr[AW-1:0];
    assign mem_din     = s_data;
    assign mem_rd_addr = rd_ptr[AW-1:0];
    assign m_data      = mem_dout;

    // Wrap bit makes the modular difference exact over 0..2**AW
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = (count >= AFULL_LVL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule
